// File: rtl/arp_sequencer_if.sv
// arp_sequencer_if: control, key and note lines between scanner, arpeggiator and voice allocator
interface arp_sequencer_if #(
  parameter int NUM_KEYS = 8,
  parameter int CNT_W = 16
);
  logic enable;
  logic [1:0] mode;
  logic [CNT_W-1:0] step_len;
  logic [CNT_W-1:0] gate_len;
  logic latch;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] notes_on;
  logic step_strobe;
  logic [$clog2(NUM_KEYS)-1:0] cur_idx;
  modport master (
    output enable, mode, step_len, gate_len, latch, keys,
    input notes_on, step_strobe, cur_idx
  );
  modport slave (
    input enable, mode, step_len, gate_len, latch, keys,
    output notes_on, step_strobe, cur_idx
  );
endinterface

// File: rtl/arp_sequencer.sv
// arp_sequencer: key pass-through, or up/down/ping-pong/random arpeggio over held or latched keys
module arp_sequencer #(
  parameter int NUM_KEYS = 8,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RESET,
  arp_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_KEYS);
  typedef enum logic [1:0] {BYPASS, IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic up_q, up_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [NUM_KEYS-1:0] latched_q, latched_d, mask;
  logic [IW:0] lo, hi, nxt_up, nxt_dn, pp_fwd, pp_rev, nxt;
  logic adv;
  // search helpers return {found, index}
  function automatic logic [IW:0] first_up(input logic [NUM_KEYS-1:0] m, input int from);
    first_up = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (m[IW'(k)] && k >= from) first_up = {1'b1, IW'(k)};
  endfunction
  function automatic logic [IW:0] first_dn(input logic [NUM_KEYS-1:0] m, input int from);
    first_dn = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (m[IW'(k)] && k <= from) first_dn = {1'b1, IW'(k)};
  endfunction
  function automatic logic [IW:0] pick_rand(input logic [NUM_KEYS-1:0] m, input logic [IW-1:0] s);
    logic [IW-1:0] j;
    pick_rand = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      j = s + IW'(k);
      if (m[j]) pick_rand = {1'b1, j};
    end
  endfunction
  always_comb begin
    mask = bus.latch ? (latched_q | bus.keys) : bus.keys;
    latched_d = bus.latch ? (latched_q | bus.keys) : '0;
    lo = first_up(mask, 0);
    hi = first_dn(mask, NUM_KEYS - 1);
    nxt_up = first_up(mask, int'(idx_q) + 1);
    nxt_dn = first_dn(mask, int'(idx_q) - 1);
    pp_fwd = up_q ? nxt_up : nxt_dn;
    pp_rev = up_q ? nxt_dn : nxt_up;
    nxt = bus.mode == 2'd0 ? (nxt_up[IW] ? nxt_up : lo)
        : bus.mode == 2'd1 ? (nxt_dn[IW] ? nxt_dn : hi)
        : bus.mode == 2'd2 ? (pp_fwd[IW] ? pp_fwd : pp_rev)
        : pick_rand(mask, lfsr_q[IW-1:0]);
    adv = cnt_q == bus.step_len || !mask[idx_q];
    state_d = state_q;
    cnt_d = '0;
    idx_d = idx_q;
    up_d = up_q;
    lfsr_d = lfsr_q;
    if (!bus.enable) begin
      state_d = BYPASS;
      up_d = 1'b1;
    end else if (state_q == BYPASS) begin
      state_d = IDLE;
      up_d = 1'b1;
    end else if (state_q == IDLE) begin
      state_d = |mask ? PLAY : IDLE;
      idx_d = !(|mask) ? idx_q : bus.mode == 2'd1 ? hi[IW-1:0] : lo[IW-1:0];
    end else if (adv) begin
      state_d = |mask ? PLAY : IDLE;
      idx_d = nxt[IW] ? nxt[IW-1:0] : idx_q;
      up_d = (bus.mode == 2'd2 && !pp_fwd[IW] && pp_rev[IW]) ? !up_q : up_q;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else
      cnt_d = cnt_q + CNT_W'(1);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= BYPASS;
      cnt_q <= '0;
      idx_q <= '0;
      up_q <= 1'b1;
      lfsr_q <= 16'hACE1;
      latched_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      up_q <= up_d;
      lfsr_q <= lfsr_d;
      latched_q <= latched_d;
    end
  end
  assign bus.notes_on = RESET ? '0
                      : state_q == BYPASS ? bus.keys
                      : (state_q == PLAY && cnt_q < bus.gate_len && mask[idx_q]) ? NUM_KEYS'(1) << idx_q
                      : '0;
  assign bus.step_strobe = !RESET && state_q == PLAY && cnt_q == '0;
  assign bus.cur_idx = idx_q;
endmodule
